// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helper for the
// sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_RSV3 = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_RSV5 = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1010;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b1011;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1101;
    localparam logic [OP_W-1:0] OP_DIVU = 4'b1110;
    localparam logic [OP_W-1:0] OP_REMU = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_multicycle(input logic [OP_W-1:0] op);
        case (op)
            OP_MUL, OP_DIVU, OP_REMU: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per clock.
// result/ovf/done are valid combinationally during the final iteration cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf,
    output logic                  done
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    logic [OP_W-1:0]  op_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [2*W-1:0]   acc_r;
    logic [CNT_W-1:0] cnt_r;

    logic [W:0]       mul_sum_s;
    logic [W:0]       div_shift_s;
    logic             div_ge_s;
    logic [W-1:0]     div_rem_s;
    logic [2*W-1:0]   acc_nxt_s;

    // One iteration step; acc holds {partial product | multiplier} or {remainder | quotient}
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        div_rem_s   = div_shift_s[W-1:0] - b_r;
        case (op_r)
            OP_MUL:           acc_nxt_s = {mul_sum_s, acc_r[W-1:1]};
            OP_DIVU, OP_REMU: acc_nxt_s = {(div_ge_s ? div_rem_s : div_shift_s[W-1:0]),
                                           acc_r[W-2:0], div_ge_s};
            default:          acc_nxt_s = acc_r;
        endcase
    end

    // Final result selection and overflow from the post-iteration accumulator
    always_comb begin
        case (op_r)
            OP_REMU: result = acc_nxt_s[2*W-1:W];
            default: result = acc_nxt_s[W-1:0];
        endcase
        case (op_r)
            OP_MUL:           ovf = |acc_nxt_s[2*W-1:W];
            OP_DIVU, OP_REMU: ovf = (b_r == {W{1'b0}});
            default:          ovf = 1'b0;
        endcase
        done = (cnt_r == CNT_ONE);
    end

    // Operand latch, accumulator iteration and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= OP_AND;
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
            acc_r <= {(2*W){1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (start) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            acc_r <= (op == OP_MUL) ? {{W{1'b0}}, b} : {{W{1'b0}}, a};
            cnt_r <= CNT_FULL;
        end else if (cnt_r != CNT_ZERO) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU: single-cycle ops complete in one clock, MUL/DIVU/REMU
// iterate for DATA_WIDTH clocks in alu_muldiv_iter. One operation in flight at most.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    zero_flag,
    output logic                    overflow_flag,
    output logic                    busy
);

    localparam int W           = DATA_WIDTH;
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    state_t           state_r, state_nxt_s;
    logic             out_valid_r;
    logic [W-1:0]     result_r;
    logic             zero_r;
    logic             ovf_r;

    logic             accept_s;
    logic             start_mc_s;
    logic             sub_s;
    logic [W-1:0]     b_eff_s;
    logic [W-1:0]     sum_s;
    logic             add_ovf_s;
    logic [SHAMT_WIDTH-1:0] shamt_s;
    logic [W-1:0]     sra_s;
    logic [W-1:0]     sc_result_s;
    logic             sc_ovf_s;
    logic [W-1:0]     md_result_s;
    logic             md_ovf_s;
    logic             md_done_s;

    assign in_ready   = (state_r == ST_IDLE) & (~out_valid_r | out_ready) & ~rst;
    assign accept_s   = in_valid & in_ready;
    assign start_mc_s = accept_s & is_multicycle(alu_op);

    // Shared adder: SUB and SLT feed ~B with carry-in 1
    assign sub_s     = (alu_op == OP_SUB) | (alu_op == OP_SLT);
    assign b_eff_s   = sub_s ? ~operand_b : operand_b;
    assign sum_s     = operand_a + b_eff_s + {{(W-1){1'b0}}, sub_s};
    assign add_ovf_s = ~(operand_a[W-1] ^ b_eff_s[W-1]) & (operand_a[W-1] ^ sum_s[W-1]);
    assign shamt_s   = operand_b[SHAMT_WIDTH-1:0];
    assign sra_s     = $unsigned($signed(operand_a) >>> shamt_s);

    // Single-cycle result and overflow selection
    always_comb begin
        sc_result_s = {W{1'b0}};
        sc_ovf_s    = 1'b0;
        case (alu_op)
            OP_AND:  sc_result_s = operand_a & operand_b;
            OP_OR:   sc_result_s = operand_a | operand_b;
            OP_XOR:  sc_result_s = operand_a ^ operand_b;
            OP_NOR:  sc_result_s = ~(operand_a | operand_b);
            OP_ADD, OP_SUB: begin
                sc_result_s = sum_s;
                sc_ovf_s    = add_ovf_s;
            end
            OP_SLT:  sc_result_s = {{(W-1){1'b0}}, sum_s[W-1] ^ add_ovf_s};
            OP_SLTU: sc_result_s = {{(W-1){1'b0}}, (operand_a < operand_b)};
            OP_SLL:  sc_result_s = operand_a << shamt_s;
            OP_SRL:  sc_result_s = operand_a >> shamt_s;
            OP_SRA:  sc_result_s = sra_s;
            default: begin
                sc_result_s = {W{1'b0}};
                sc_ovf_s    = 1'b0;
            end
        endcase
    end

    alu_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_mc_s),
        .op     (alu_op),
        .a      (operand_a),
        .b      (operand_b),
        .result (md_result_s),
        .ovf    (md_ovf_s),
        .done   (md_done_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_mc_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output register; a fresh single-cycle accept overrides the consume-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {W{1'b0}};
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (accept_s && !is_multicycle(alu_op)) begin
            out_valid_r <= 1'b1;
            result_r    <= sc_result_s;
            zero_r      <= (sc_result_s == {W{1'b0}});
            ovf_r       <= sc_ovf_s;
        end else if (md_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= md_result_s;
            zero_r      <= (md_result_s == {W{1'b0}});
            ovf_r       <= md_ovf_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid     = out_valid_r;
    assign alu_result    = result_r;
    assign zero_flag     = zero_r;
    assign overflow_flag = ovf_r;
    assign busy          = (state_r == ST_BUSY);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATA_WIDTH = 32), one task per scenario.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic        overflow_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
    } vec_t;

    alu_seq #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .alu_op        (alu_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        operand_a = 32'h0; operand_b = 32'h0; alu_op = OP_AND;
        tick(); tick();
        checks++;
        if ({out_valid, alu_result, zero_flag, overflow_flag, busy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%h z=%b o=%b busy=%b, want all 0",
                     out_valid, alu_result, zero_flag, overflow_flag, busy);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_logic_arith();
        vec_t tbl [8];
        tbl = '{
            '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
            '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0},
            '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
            '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0},
            '{OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0},
            '{OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0},
            '{OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu_op = tbl[i].op; operand_a = tbl[i].a; operand_b = tbl[i].b; in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL arith_in_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, alu_result, zero_flag, overflow_flag} !== {1'b1, tbl[i].res, tbl[i].z, tbl[i].o}) begin
                errors++;
                $display("FAIL arith[%0d] got v=%b r=%h z=%b o=%b want v=1 r=%h z=%b o=%b",
                         i, out_valid, alu_result, zero_flag, overflow_flag, tbl[i].res, tbl[i].z, tbl[i].o);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL arith_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_compare_shift();
        vec_t tbl [12];
        tbl = '{
            '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
            '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
            '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0},
            '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0},
            '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
            '{OP_RSV3, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
            '{OP_RSV5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0},
            '{OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0},
            '{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0},
            '{OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0},
            '{OP_SRA,  32'h40000000, 32'h00000024, 32'h04000000, 1'b0, 1'b0},
            '{OP_SRL,  32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            alu_op = tbl[i].op; operand_a = tbl[i].a; operand_b = tbl[i].b; in_valid = 1'b1;
            tick();
            checks++;
            if ({out_valid, alu_result, zero_flag, overflow_flag} !== {1'b1, tbl[i].res, tbl[i].z, tbl[i].o}) begin
                errors++;
                $display("FAIL cmp_shift[%0d] got v=%b r=%h z=%b o=%b want v=1 r=%h z=%b o=%b",
                         i, out_valid, alu_result, zero_flag, overflow_flag, tbl[i].res, tbl[i].z, tbl[i].o);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    // Drives one multi-cycle op; garbage requests are held during BUSY and must be ignored
    task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output logic hold_ok);
        alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
        tick();
        alu_op = OP_ADD; operand_a = ~a; operand_b = 32'h5;
        hold_ok = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) hold_ok = 1'b0;
            tick();
            if (out_valid === 1'b1) lat = k;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_muldiv();
        vec_t tbl [7];
        int   lat;
        logic hold_ok;
        tbl = '{
            '{OP_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1},
            '{OP_MUL,  32'h00000006, 32'h00000007, 32'h0000002A, 1'b0, 1'b0},
            '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1},
            '{OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0},
            '{OP_REMU, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0},
            '{OP_DIVU, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1},
            '{OP_REMU, 32'h00000009, 32'h00000000, 32'h00000009, 1'b0, 1'b1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_multi(tbl[i].op, tbl[i].a, tbl[i].b, lat, hold_ok);
            checks++;
            if (lat != 32) begin
                errors++; $display("FAIL muldiv_latency[%0d] got %0d want 32", i, lat);
            end
            checks++;
            if (hold_ok !== 1'b1) begin
                errors++; $display("FAIL muldiv_busy_hold[%0d] got ok=%b want 1", i, hold_ok);
            end
            checks++;
            if ({out_valid, busy, alu_result, zero_flag, overflow_flag} !== {1'b1, 1'b0, tbl[i].res, tbl[i].z, tbl[i].o}) begin
                errors++;
                $display("FAIL muldiv[%0d] got v=%b busy=%b r=%h z=%b o=%b want v=1 busy=0 r=%h z=%b o=%b",
                         i, out_valid, busy, alu_result, zero_flag, overflow_flag, tbl[i].res, tbl[i].z, tbl[i].o);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        alu_op = OP_ADD; operand_a = 32'h7FFFFFFF; operand_b = 32'h00000001; in_valid = 1'b1;
        tick();
        alu_op = OP_SUB; operand_a = 32'd50; operand_b = 32'd8;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_valid, alu_result, zero_flag, overflow_flag, in_ready} !== {1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got v=%b r=%h z=%b o=%b rdy=%b want v=1 r=80000000 z=0 o=1 rdy=0",
                         k, out_valid, alu_result, zero_flag, overflow_flag, in_ready);
            end
            tick();
        end
        out_ready = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, alu_result, zero_flag, overflow_flag} !== {1'b1, 32'd42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back got v=%b r=%h z=%b o=%b want v=1 r=0000002a z=0 o=0",
                     out_valid, alu_result, zero_flag, overflow_flag);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic seen_valid;
        out_ready = 1'b1;
        alu_op = OP_MUL; operand_a = 32'd6; operand_b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before got %b want 1", busy);
        end
        rst = 1'b1; #1;
        checks++;
        if ({out_valid, alu_result, zero_flag, overflow_flag, busy, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_outputs got v=%b r=%h z=%b o=%b busy=%b rdy=%b want all 0",
                     out_valid, alu_result, zero_flag, overflow_flag, busy, in_ready);
        end
        tick();
        rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_in_ready got %b want 1", in_ready);
        end
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_result got activity=%b want 0", seen_valid);
        end
    endtask

    initial begin
        test_reset();
        test_logic_arith();
        test_compare_shift();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
